// File: rtl/qrs_pkg.sv
// Shared types and width helpers for the QRS detector slice.
package qrs_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ABOVE   = 2'd1,
        REFRACT = 2'd2
    } qrs_state_t;

    localparam int unsigned N_DEF     = 32;
    localparam int unsigned WIN_DEF   = 8;
    localparam int unsigned IDX_W     = 16;
    localparam int unsigned SUM_W_DEF = N_DEF + $clog2(WIN_DEF);

    // Magnitude of an N-bit signed sample always fits in N-1 bits after saturation.
    function automatic int unsigned mag_width(input int unsigned n);
        return n - 1;
    endfunction

    function automatic int unsigned sum_width(input int unsigned n, input int unsigned win);
        return n + $clog2(win);
    endfunction

endpackage

// File: rtl/qrs_mwi.sv
// Moving-window integrator: saturating absolute value, WIN-deep history and running sum.
module qrs_mwi
    import qrs_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned WIN = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_valid,
    input  logic signed [N-1:0]        i_data,
    output logic [N+$clog2(WIN)-1:0]   o_sum_next
);

    localparam int unsigned MW = mag_width(N);
    localparam int unsigned SW = sum_width(N, WIN);

    logic          w_is_min;
    logic [MW-1:0] w_mag;
    logic [MW-1:0] r_win [WIN];
    logic [SW-1:0] r_sum;
    logic [SW-1:0] w_sum_next;

    // Low N-1 bits of two's-complement negation suffice because |x| < 2^(N-1) once -2^(N-1) is trapped.
    always_comb begin
        w_is_min = i_data[N-1] && (i_data[N-2:0] == '0);
        if (w_is_min) begin
            w_mag = '1;
        end else if (i_data[N-1]) begin
            w_mag = ~i_data[N-2:0] + 1'b1;
        end else begin
            w_mag = i_data[N-2:0];
        end
    end

    always_comb begin
        w_sum_next = r_sum + SW'(w_mag) - SW'(r_win[WIN-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                r_win[i] <= '0;
            end
            r_sum <= '0;
        end else if (i_valid) begin
            r_win[0] <= w_mag;
            for (int unsigned i = 1; i < WIN; i++) begin
                r_win[i] <= r_win[i-1];
            end
            r_sum <= w_sum_next;
        end
    end

    assign o_sum_next = w_sum_next;

endmodule

// File: rtl/qrs_detect.sv
// R-peak detector: threshold/maximum tracking FSM with refractory hold-off over the MWI sum.
module qrs_detect #(
    parameter int unsigned N       = 32,
    parameter int unsigned WIN     = 8,
    parameter int unsigned TH      = 1000,
    parameter int unsigned REFRACT = 50
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic signed [N-1:0]        in_data,
    output logic                       peak_valid,
    output logic [15:0]                peak_index,
    output logic [N+$clog2(WIN)-1:0]   peak_amp
);

    import qrs_pkg::*;

    localparam int unsigned SW   = sum_width(N, WIN);
    localparam int unsigned RC_W = $clog2(REFRACT + 1);
    localparam logic [SW-1:0]   TH_S  = SW'(TH);
    localparam logic [RC_W-1:0] RC_LD = RC_W'(REFRACT);

    qrs_state_t        r_state;
    qrs_state_t        w_state_next;
    logic [SW-1:0]     w_s;
    logic              w_ge;
    logic              w_load_max;
    logic              w_fire;
    logic              w_rc_dec;
    logic [SW-1:0]     r_max;
    logic [IDX_W-1:0]  r_max_idx;
    logic [IDX_W-1:0]  r_idx;
    logic [RC_W-1:0]   r_rcnt;
    logic              r_peak_valid;
    logic [IDX_W-1:0]  r_peak_index;
    logic [SW-1:0]     r_peak_amp;

    qrs_mwi #(
        .N   (N),
        .WIN (WIN)
    ) u_mwi (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (in_valid),
        .i_data     (in_data),
        .o_sum_next (w_s)
    );

    assign w_ge = (w_s >= TH_S);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= qrs_pkg::SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (in_valid) begin
            case (r_state)
                qrs_pkg::SEARCH:  if (w_ge) w_state_next = qrs_pkg::ABOVE;
                qrs_pkg::ABOVE:   if (!w_ge) w_state_next = qrs_pkg::REFRACT;
                qrs_pkg::REFRACT: if (r_rcnt == RC_W'(1)) w_state_next = qrs_pkg::SEARCH;
                default:          w_state_next = qrs_pkg::SEARCH;
            endcase
        end
    end

    // Strict '>' in ABOVE keeps the earliest index on equal sums.
    always_comb begin
        w_load_max = 1'b0;
        w_fire     = 1'b0;
        w_rc_dec   = 1'b0;
        if (in_valid) begin
            case (r_state)
                qrs_pkg::SEARCH:  w_load_max = w_ge;
                qrs_pkg::ABOVE: begin
                    w_load_max = w_ge && (w_s > r_max);
                    w_fire     = !w_ge;
                end
                qrs_pkg::REFRACT: w_rc_dec = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_max        <= '0;
            r_max_idx    <= '0;
            r_rcnt       <= '0;
            r_peak_valid <= 1'b0;
            r_peak_index <= '0;
            r_peak_amp   <= '0;
        end else begin
            r_peak_valid <= w_fire;
            if (in_valid) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_load_max) begin
                r_max     <= w_s;
                r_max_idx <= r_idx;
            end
            if (w_fire) begin
                r_peak_amp   <= r_max;
                r_peak_index <= r_max_idx;
                r_rcnt       <= RC_LD;
            end else if (w_rc_dec) begin
                r_rcnt <= r_rcnt - 1'b1;
            end
        end
    end

    assign peak_valid = r_peak_valid;
    assign peak_index = r_peak_index;
    assign peak_amp   = r_peak_amp;

endmodule
